// File: rtl/uart_tx_stream_arbiter_pkg.sv
// Package: uart_tx_stream_arbiter_pkg
// Shared types and helpers for the UART TX stream arbiter and its
// round-robin picker.
//   arb_state_t : lock FSM state (ARB_IDLE / ARB_LOCKED)
//   idx_width   : index width for n requesters, never below 1 bit
//   wrap_idx    : (base + off) modulo n, for base < n and off < n
package uart_tx_stream_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/uart_tx_stream_arbiter_if.sv
// Interface: uart_tx_stream_arbiter_if
// Bundles the NUM_SOURCES AXI-Stream byte producers and the single shared
// output stream towards the UART tx_stream sink.
//   s_tdata/s_tvalid/s_tlast : per-source stream, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tready                 : per-source ready back to the producers
//   m_tdata/m_tvalid/m_tlast : shared stream to the UART
//   m_tready                 : UART ready
// Modports: slave  = arbiter view, master = producers + UART view.
interface uart_tx_stream_arbiter_if #(
    parameter int NUM_SOURCES = 3,
    parameter int DATA_WIDTH  = 8
);
    logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata;
    logic [NUM_SOURCES-1:0]            s_tvalid;
    logic [NUM_SOURCES-1:0]            s_tlast;
    logic [NUM_SOURCES-1:0]            s_tready;
    logic [DATA_WIDTH-1:0]             m_tdata;
    logic                              m_tvalid;
    logic                              m_tlast;
    logic                              m_tready;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/uart_tx_stream_arbiter_rr_arbiter_pick.sv
// Module: rr_arbiter_pick
// Combinational round-robin pick: finds the first set bit of req searching
// upward from ptr and wrapping NUM_REQ-1 -> 0.
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    highest-priority position (must be < NUM_REQ)
//   found out 1        at least one request set
//   idx   out IDX_W    index of the winning request (0 when none)
module rr_arbiter_pick
    import uart_tx_stream_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // cand[k] is the position k steps past ptr, i.e. priority rank k
    logic [IDX_W-1:0] cand [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = IDX_W'(wrap_idx(int'(ptr), gi, NUM_REQ));
        end
    endgenerate

    // Scan from lowest priority to highest so the last hit wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_stream_arbiter.sv
// Module: uart_tx_stream_arbiter
// Packet-locked round-robin arbiter sharing one byte-wide UART TX stream
// between NUM_SOURCES AXI-Stream producers. A source is granted after one
// arbitration bubble cycle, keeps the lock until its tlast beat completes,
// then priority rotates to the next source.
// Ports:
//   clk         in   system clock (clk_100)
//   reset       in   asynchronous active-low reset
//   bus         if   uart_tx_stream_arbiter_if.slave (s_* sources, m_* UART)
//   grant_valid out  a source currently holds the lock
//   grant_idx   out  index of the locked source
//   wdog_abort  out  1-cycle pulse when the watchdog releases a stalled lock
// Optional feature: define UART_ARB_WATCHDOG_EN to release a lock whose
// granted source has stopped presenting data for WDOG_CYCLES cycles.
module uart_tx_stream_arbiter
    import uart_tx_stream_arbiter_pkg::*;
#(
    parameter  int NUM_SOURCES = 3,
    parameter  int DATA_WIDTH  = 8,
    parameter  int WDOG_CYCLES = 100000,
    localparam int IDX_W       = idx_width(NUM_SOURCES)
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_tx_stream_arbiter_if.slave bus,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  wdog_abort
);

    arb_state_t             state_reg;
    logic [IDX_W-1:0]       rr_ptr_reg;
    logic [IDX_W-1:0]       grant_idx_reg;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic                   locked;
    logic                   beat;
    logic [IDX_W-1:0]       rr_ptr_next;

    logic [DATA_WIDTH-1:0]  mux_tdata;
    logic                   mux_tvalid;
    logic                   mux_tlast;
    logic [NUM_SOURCES-1:0] mux_tready;

    rr_arbiter_pick #(
        .NUM_REQ (NUM_SOURCES)
    ) u_pick (
        .req   (bus.s_tvalid),
        .ptr   (rr_ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign locked      = (state_reg == ARB_LOCKED);
    assign beat        = mux_tvalid & bus.m_tready;
    assign rr_ptr_next = IDX_W'(wrap_idx(int'(grant_idx_reg), 1, NUM_SOURCES));

    // Zero-latency pass-through of the locked source; everything is held
    // at 0 while idle so reset and arbitration cycles present nothing.
    always_comb begin
        mux_tdata  = '0;
        mux_tvalid = 1'b0;
        mux_tlast  = 1'b0;
        mux_tready = '0;
        if (locked) begin
            mux_tdata                 = bus.s_tdata[grant_idx_reg*DATA_WIDTH +: DATA_WIDTH];
            mux_tvalid                = bus.s_tvalid[grant_idx_reg];
            mux_tlast                 = bus.s_tlast[grant_idx_reg];
            mux_tready[grant_idx_reg] = bus.m_tready;
        end
    end

    assign bus.m_tdata  = mux_tdata;
    assign bus.m_tvalid = mux_tvalid;
    assign bus.m_tlast  = mux_tlast;
    assign bus.s_tready = mux_tready;
    assign grant_valid  = locked;
    assign grant_idx    = grant_idx_reg;

`ifdef UART_ARB_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_reg;
    logic              wdog_abort_reg;
    logic              wdog_stall;

    // Only a source with nothing to offer counts; back-pressure from the
    // UART (valid high, ready low) never does.
    assign wdog_stall = locked & ~bus.s_tvalid[grant_idx_reg];
    assign wdog_abort = wdog_abort_reg;
`else
    assign wdog_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ARB_IDLE;
            rr_ptr_reg     <= '0;
            grant_idx_reg  <= '0;
`ifdef UART_ARB_WATCHDOG_EN
            wdog_cnt_reg   <= '0;
            wdog_abort_reg <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_WATCHDOG_EN
            wdog_abort_reg <= 1'b0;
`endif
            case (state_reg)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_idx_reg <= pick_idx;
                        state_reg     <= ARB_LOCKED;
`ifdef UART_ARB_WATCHDOG_EN
                        wdog_cnt_reg  <= '0;
`endif
                    end
                end
                ARB_LOCKED: begin
                    if (beat && mux_tlast) begin
                        state_reg  <= ARB_IDLE;
                        rr_ptr_reg <= rr_ptr_next;
                    end
`ifdef UART_ARB_WATCHDOG_EN
                    else if (beat) begin
                        wdog_cnt_reg <= '0;
                    end else if (wdog_stall) begin
                        if (wdog_cnt_reg == WDOG_W'(WDOG_CYCLES - 1)) begin
                            // Truncate the packet: no tlast is generated
                            state_reg      <= ARB_IDLE;
                            rr_ptr_reg     <= rr_ptr_next;
                            wdog_abort_reg <= 1'b1;
                        end else begin
                            wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
                        end
                    end
`endif
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

endmodule
